alu_cmd_sequencer: RTL



---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_seq_regfile.sv | 41 ++++
 rtl/alu_cmd_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared state encoding and default widths for the ALU command
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int c_DEF_OPCODE_SIZE = 3;
    localparam int c_DEF_DATA_SIZE   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_regfile
// Description : REG_COUNT x DATA_SIZE register file, one synchronous write
//               port, two combinational read ports, cleared on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_regfile #(
    parameter int DATA_SIZE = 8,
    parameter int REG_COUNT = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [ADDR_W-1:0]    i_raddr1,
    input  logic [ADDR_W-1:0]    i_raddr2,
    output logic [DATA_SIZE-1:0] o_rdata1,
    output logic [DATA_SIZE-1:0] o_rdata2
);

    logic [DATA_SIZE-1:0] r_mem [REG_COUNT];

    // Storage: clear every entry on reset, otherwise single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Accepts operate commands, fetches operands from a local
//               register file, drives a registered ALU, waits out its latency
//               and writes the result back. Host load port fills registers
//               while idle.
//               Optional macro ALU_SEQ_ZERO_FLAG_EN adds the res_zero output.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OPCODE_SIZE = c_DEF_OPCODE_SIZE,
    parameter int DATA_SIZE   = c_DEF_DATA_SIZE,
    parameter int REG_COUNT   = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [OPCODE_SIZE-1:0]        cmd_func,
    input  logic [$clog2(REG_COUNT)-1:0]  cmd_src1,
    input  logic [$clog2(REG_COUNT)-1:0]  cmd_src2,
    input  logic [$clog2(REG_COUNT)-1:0]  cmd_dst,
    input  logic                          load_en,
    input  logic [$clog2(REG_COUNT)-1:0]  load_addr,
    input  logic [DATA_SIZE-1:0]          load_data,
    output logic                          load_drop,
    output logic [OPCODE_SIZE-1:0]        alu_func,
    output logic [DATA_SIZE-1:0]          alu_data1,
    output logic [DATA_SIZE-1:0]          alu_data2,
    input  logic [DATA_SIZE-1:0]          alu_result,
    output logic                          res_valid,
    output logic [DATA_SIZE-1:0]          res_data,
    output logic                          busy
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                          res_zero
`endif
);

    localparam int c_RA        = $clog2(REG_COUNT);
    localparam int c_CW        = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam int c_WAIT_LAST = (ALU_LATENCY > 1) ? (ALU_LATENCY - 2) : 0;

    seq_state_t r_state;
    seq_state_t w_next;

    logic [c_CW-1:0]        r_wait_cnt;
    logic [c_RA-1:0]        r_dst;
    logic [OPCODE_SIZE-1:0] r_alu_func;
    logic [DATA_SIZE-1:0]   r_alu_d1;
    logic [DATA_SIZE-1:0]   r_alu_d2;

    logic                   w_idle;
    logic                   w_wb;
    logic                   w_accept;
    logic                   w_we;
    logic [c_RA-1:0]        w_waddr;
    logic [DATA_SIZE-1:0]   w_wdata;
    logic [DATA_SIZE-1:0]   w_rd1;
    logic [DATA_SIZE-1:0]   w_rd2;
    logic [DATA_SIZE-1:0]   w_op1;
    logic [DATA_SIZE-1:0]   w_op2;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_wb     = (r_state == ST_WB);
    assign w_accept = w_idle & cmd_valid;

    // Single RF write port: host loads only in IDLE, writeback only in WB,
    // so the two sources never collide.
    assign w_we    = (w_idle & load_en) | w_wb;
    assign w_waddr = w_wb ? r_dst : load_addr;
    assign w_wdata = w_wb ? alu_result : load_data;

    alu_seq_regfile #(
        .DATA_SIZE (DATA_SIZE),
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (c_RA)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr1 (cmd_src1),
        .i_raddr2 (cmd_src2),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    // Operands are captured on the accept edge so the ALU sees them during
    // ISSUE; a load landing in the same cycle is forwarded so the command
    // observes the freshly loaded value.
    assign w_op1 = (load_en && (load_addr == cmd_src1)) ? load_data : w_rd1;
    assign w_op2 = (load_en && (load_addr == cmd_src2)) ? load_data : w_rd2;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (cmd_valid) w_next = ST_ISSUE;
            ST_ISSUE: w_next = (ALU_LATENCY > 1) ? ST_WAIT : ST_WB;
            ST_WAIT:  if (r_wait_cnt == c_CW'(c_WAIT_LAST)) w_next = ST_WB;
            ST_WB:    w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // WAIT-state cycle counter, cleared while in ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_CW'(1);
        end
    end

    // ALU drive registers and destination latch; held until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_func <= '0;
            r_alu_d1   <= '0;
            r_alu_d2   <= '0;
            r_dst      <= '0;
        end else if (w_accept) begin
            r_alu_func <= cmd_func;
            r_alu_d1   <= w_op1;
            r_alu_d2   <= w_op2;
            r_dst      <= cmd_dst;
        end
    end

    assign alu_func  = r_alu_func;
    assign alu_data1 = r_alu_d1;
    assign alu_data2 = r_alu_d2;

    assign cmd_ready = w_idle;
    assign busy      = ~w_idle;
    assign load_drop = load_en & ~w_idle;
    assign res_valid = w_wb;
    assign res_data  = w_wb ? alu_result : '0;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign res_zero = w_wb & (alu_result == '0);
`endif

endmodule
`default_nettype wire
